// File: rtl/asrv32_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming instruction,
// a registered output slot plus one skid entry so fetch can keep streaming
// at full rate while execute applies backpressure, and a flush for redirects.
module asrv32_decode_stage #(
  parameter int unsigned PC_WIDTH         = 32,
  parameter bit          EN_ILLEGAL_CHECK = 1'b1,
  parameter int unsigned ALU_WIDTH        = 14,
  parameter int unsigned OPCODE_WIDTH     = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [31:0]             i_inst,
  input  logic [PC_WIDTH-1:0]     i_pc,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [PC_WIDTH-1:0]     o_pc,
  output logic [4:0]              o_rs1_addr,
  output logic [4:0]              o_rs2_addr,
  output logic [4:0]              o_rd_addr,
  output logic [31:0]             o_imm,
  output logic [2:0]              o_funct3,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [ALU_WIDTH-1:0]    o_alu_op,
  output logic                    o_illegal
);

  // One-hot bit positions shared with the rest of the core.
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_AND  = 6;
  localparam int unsigned ALU_SLL  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SRA  = 9;
  localparam int unsigned ALU_EQ   = 10;
  localparam int unsigned ALU_NEQ  = 11;
  localparam int unsigned ALU_GE   = 12;
  localparam int unsigned ALU_GEU  = 13;

  localparam int unsigned OP_RTYPE  = 0;
  localparam int unsigned OP_ITYPE  = 1;
  localparam int unsigned OP_LOAD   = 2;
  localparam int unsigned OP_STORE  = 3;
  localparam int unsigned OP_BRANCH = 4;
  localparam int unsigned OP_JAL    = 5;
  localparam int unsigned OP_JALR   = 6;
  localparam int unsigned OP_LUI    = 7;
  localparam int unsigned OP_AUIPC  = 8;
  localparam int unsigned OP_SYSTEM = 9;
  localparam int unsigned OP_FENCE  = 10;

  typedef enum logic [6:0] {
    OPC_RTYPE  = 7'b0110011,
    OPC_ITYPE  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011,
    OPC_FENCE  = 7'b0001111
  } opc_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]     pc;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [31:0]             imm;
    logic [2:0]              funct3;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ALU_WIDTH-1:0]    alu_op;
    logic                    illegal;
  } dec_t;

  opc_e       opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       known;
  logic       bad;
  dec_t       dec_d;
  dec_t       out_q;
  dec_t       skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;
  logic       ready_q;
  logic       accept;

  assign opc    = opc_e'(i_inst[6:0]);
  assign funct3 = i_inst[14:12];
  assign funct7 = i_inst[31:25];

  // Shared R/I-type ALU selection; alt is inst[30] (SUB only for R, SRA for both).
  function automatic logic [ALU_WIDTH-1:0] rr_alu(input logic [2:0] f3,
                                                  input logic alt,
                                                  input logic is_r);
    logic [ALU_WIDTH-1:0] a;
    a = '0;
    case (f3)
      3'b000:  if (is_r && alt) a[ALU_SUB] = 1'b1; else a[ALU_ADD] = 1'b1;
      3'b001:  a[ALU_SLL] = 1'b1;
      3'b010:  a[ALU_SLT] = 1'b1;
      3'b011:  a[ALU_SLTU] = 1'b1;
      3'b100:  a[ALU_XOR] = 1'b1;
      3'b101:  if (alt) a[ALU_SRA] = 1'b1; else a[ALU_SRL] = 1'b1;
      3'b110:  a[ALU_OR] = 1'b1;
      default: a[ALU_AND] = 1'b1;
    endcase
    return a;
  endfunction

  // Instruction decode: fields, immediate, class, ALU op and illegal detection.
  always_comb begin
    dec_d        = '0;
    dec_d.pc     = i_pc;
    dec_d.funct3 = funct3;
    dec_d.rs1    = i_inst[19:15];
    dec_d.rd     = i_inst[11:7];
    known        = 1'b1;
    bad          = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        dec_d.opcode[OP_RTYPE] = 1'b1;
        dec_d.rs2    = i_inst[24:20];
        dec_d.alu_op = rr_alu(funct3, i_inst[30], 1'b1);
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) bad = 1'b1;
        if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) bad = 1'b1;
      end
      OPC_ITYPE: begin
        dec_d.opcode[OP_ITYPE] = 1'b1;
        dec_d.imm    = {{20{i_inst[31]}}, i_inst[31:20]};
        dec_d.alu_op = rr_alu(funct3, i_inst[30], 1'b0);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) bad = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) bad = 1'b1;
      end
      OPC_LOAD: begin
        dec_d.opcode[OP_LOAD]   = 1'b1;
        dec_d.imm               = {{20{i_inst[31]}}, i_inst[31:20]};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
      end
      OPC_STORE: begin
        dec_d.opcode[OP_STORE]  = 1'b1;
        dec_d.rs2               = i_inst[24:20];
        dec_d.rd                = '0;
        dec_d.imm               = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
        if (funct3 >= 3'b011) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.opcode[OP_BRANCH] = 1'b1;
        dec_d.rs2               = i_inst[24:20];
        dec_d.rd                = '0;
        dec_d.imm               = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                   i_inst[30:25], i_inst[11:8], 1'b0};
        case (funct3)
          3'b000:  dec_d.alu_op[ALU_EQ]   = 1'b1;
          3'b001:  dec_d.alu_op[ALU_NEQ]  = 1'b1;
          3'b100:  dec_d.alu_op[ALU_SLT]  = 1'b1;
          3'b101:  dec_d.alu_op[ALU_GE]   = 1'b1;
          3'b110:  dec_d.alu_op[ALU_SLTU] = 1'b1;
          3'b111:  dec_d.alu_op[ALU_GEU]  = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_d.opcode[OP_JAL]    = 1'b1;
        dec_d.rs1               = '0;
        dec_d.imm               = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                   i_inst[20], i_inst[30:21], 1'b0};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
      end
      OPC_JALR: begin
        dec_d.opcode[OP_JALR]   = 1'b1;
        dec_d.imm               = {{20{i_inst[31]}}, i_inst[31:20]};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      OPC_LUI: begin
        dec_d.opcode[OP_LUI]    = 1'b1;
        dec_d.rs1               = '0;
        dec_d.imm               = {i_inst[31:12], 12'b0};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.opcode[OP_AUIPC]  = 1'b1;
        dec_d.rs1               = '0;
        dec_d.imm               = {i_inst[31:12], 12'b0};
        dec_d.alu_op[ALU_ADD]   = 1'b1;
      end
      OPC_SYSTEM: dec_d.opcode[OP_SYSTEM] = 1'b1;
      OPC_FENCE:  dec_d.opcode[OP_FENCE]  = 1'b1;
      default:    known = 1'b0;
    endcase
    dec_d.illegal = !known || (i_inst[1:0] != 2'b11) || (EN_ILLEGAL_CHECK && bad);
    if (dec_d.illegal) begin
      dec_d.opcode = '0;
      dec_d.alu_op = '0;
      dec_d.imm    = '0;
    end
  end

  assign o_ready = ready_q && i_rst_n;
  assign accept  = i_valid && o_ready;

  // Handshake: output slot refills from skid first, otherwise from the decoder;
  // an accept while the output is held lands in the skid entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (i_flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (!out_valid_q || i_ready) begin
      // o_ready is low whenever skid is full, so accept and drain never collide.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) out_q <= dec_d;
      end
      ready_q <= 1'b1;
    end else if (accept) begin
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end

  assign o_valid    = out_valid_q;
  assign o_pc       = out_q.pc;
  assign o_rs1_addr = out_q.rs1;
  assign o_rs2_addr = out_q.rs2;
  assign o_rd_addr  = out_q.rd;
  assign o_imm      = out_q.imm;
  assign o_funct3   = out_q.funct3;
  assign o_opcode   = out_q.opcode;
  assign o_alu_op   = out_q.alu_op;
  assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_asrv32_decode_stage.sv
// Bench for asrv32_decode_stage: directed vector table, hand-written stall,
// flush and reset sequences, then random traffic against a queue-based model.
module tb_asrv32_decode_stage;

  localparam int A_ADD = 0, A_SUB = 1, A_SLT = 2, A_SLTU = 3, A_XOR = 4, A_OR = 5,
                 A_AND = 6, A_SLL = 7, A_SRL = 8, A_SRA = 9, A_EQ = 10, A_NEQ = 11,
                 A_GE = 12, A_GEU = 13;
  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYS = 9, C_FENCE = 10;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [10:0] op;
    logic [13:0] alu;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        m;
    dec_t        n;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    int          op;
    int          alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
    logic        ill_nc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, vld, flush, rdy;
  logic [31:0] inst, pc;
  logic        m_ready, m_valid, m_ill, n_ready, n_valid, n_ill;
  logic [31:0] m_pc, m_imm, n_pc, n_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, n_rs1, n_rs2, n_rd;
  logic [2:0]  m_f3, n_f3;
  logic [10:0] m_op, n_op;
  logic [13:0] m_alu, n_alu;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic rdy_m = 1'b0;
  vec_t vt[11];

  always #5 clk = ~clk;

  asrv32_decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_pc(pc), .i_valid(vld),
    .o_ready(m_ready), .i_flush(flush), .o_valid(m_valid), .i_ready(rdy),
    .o_pc(m_pc), .o_rs1_addr(m_rs1), .o_rs2_addr(m_rs2), .o_rd_addr(m_rd),
    .o_imm(m_imm), .o_funct3(m_f3), .o_opcode(m_op), .o_alu_op(m_alu),
    .o_illegal(m_ill)
  );

  asrv32_decode_stage #(.EN_ILLEGAL_CHECK(1'b0)) dut_nc (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_pc(pc), .i_valid(vld),
    .o_ready(n_ready), .i_flush(flush), .o_valid(n_valid), .i_ready(rdy),
    .o_pc(n_pc), .o_rs1_addr(n_rs1), .o_rs2_addr(n_rs2), .o_rd_addr(n_rd),
    .o_imm(n_imm), .o_funct3(n_f3), .o_opcode(n_op), .o_alu_op(n_alu),
    .o_illegal(n_ill)
  );

  function automatic logic [10:0] oh11(int i);
    return (i < 0) ? 11'd0 : (11'd1 << i);
  endfunction

  function automatic logic [13:0] oh14(int i);
    return (i < 0) ? 14'd0 : (14'd1 << i);
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic dec_t ref_dec(logic [31:0] x, bit full);
    dec_t r;
    int cls, alu, v;
    bit bad;
    logic [2:0] f3;
    logic [6:0] f7;
    int rr[8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    int br[8] = '{A_EQ, A_NEQ, -1, -1, A_SLT, A_GE, A_SLTU, A_GEU};
    f3 = x[14:12];
    f7 = x[31:25];
    r = '0;
    r.f3 = f3; r.rs1 = x[19:15]; r.rs2 = x[24:20]; r.rd = x[11:7];
    alu = -1; bad = 0; v = 0;
    case (x[6:0])
      7'h33: cls = C_R;     7'h13: cls = C_I;     7'h03: cls = C_LOAD;
      7'h23: cls = C_STORE; 7'h63: cls = C_BR;    7'h6F: cls = C_JAL;
      7'h67: cls = C_JALR;  7'h37: cls = C_LUI;   7'h17: cls = C_AUIPC;
      7'h73: cls = C_SYS;   7'h0F: cls = C_FENCE; default: cls = -1;
    endcase
    if (!(cls inside {C_R, C_STORE, C_BR})) r.rs2 = 0;
    if (cls inside {C_LUI, C_AUIPC, C_JAL}) r.rs1 = 0;
    if (cls inside {C_STORE, C_BR}) r.rd = 0;
    case (cls)
      C_I, C_LOAD, C_JALR: v = $signed(x[31:20]);
      C_STORE:             v = $signed({x[31:25], x[11:7]});
      C_BR:                v = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0});
      C_JAL:               v = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0});
      C_LUI, C_AUIPC:      v = x & 32'hFFFFF000;
      default:             v = 0;
    endcase
    r.imm = v;
    if (cls == C_R || cls == C_I) begin
      alu = rr[f3];
      if (f3 == 0 && cls == C_R && x[30]) alu = A_SUB;
      if (f3 == 5 && x[30]) alu = A_SRA;
    end else if (cls == C_BR) alu = br[f3];
    else if (cls inside {C_LOAD, C_STORE, C_JAL, C_JALR, C_LUI, C_AUIPC}) alu = A_ADD;
    case (cls)
      C_R:     bad = !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      C_I:     bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20}));
      C_BR:    bad = f3 inside {3'd2, 3'd3};
      C_LOAD:  bad = f3 inside {3'd3, 3'd6, 3'd7};
      C_STORE: bad = f3 >= 3;
      C_JALR:  bad = f3 != 0;
      default: bad = 0;
    endcase
    r.ill = (cls < 0) || (x[1:0] != 2'b11) || (full && bad);
    if (r.ill) begin
      r.op = 0; r.alu = 0; r.imm = 0;
    end else begin
      r.op = oh11(cls); r.alu = oh14(alu);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    int k;
    x = $urandom();
    k = $urandom_range(0, 13);
    case (k)
      0: x[6:0] = 7'h33;  1: x[6:0] = 7'h13;  2: x[6:0] = 7'h03;  3: x[6:0] = 7'h23;
      4: x[6:0] = 7'h63;  5: x[6:0] = 7'h6F;  6: x[6:0] = 7'h67;  7: x[6:0] = 7'h37;
      8: x[6:0] = 7'h17;  9: x[6:0] = 7'h73;  10: x[6:0] = 7'h0F;
      12: x[1:0] = 2'($urandom_range(0, 2));
      default: ;
    endcase
    if (k < 11 && $urandom_range(0, 1) == 1)
      x[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); rdy_m = 1'b0;
    end else if (flush) begin
      q.delete(); rdy_m = 1'b1;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (vld && rdy_m) begin
        e.pc = pc; e.m = ref_dec(inst, 1'b1); e.n = ref_dec(inst, 1'b0);
        q.push_back(e);
      end
      rdy_m = (q.size() < 2);
    end
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {m_ready, m_valid, m_pc, m_rs1, m_rs2, m_rd, m_imm, m_f3, m_op, m_alu, m_ill}, '0);
      chk("reset_outputs_nc", {n_ready, n_valid, n_pc, n_rs1, n_rs2, n_rd, n_imm, n_f3, n_op, n_alu, n_ill}, '0);
    end else begin
      chk("ready", {m_ready, n_ready}, {rdy_m, rdy_m});
      chk("valid", {m_valid, n_valid}, {2{q.size() > 0}});
      if (q.size() > 0) begin
        chk("data", {m_pc, m_rs1, m_rs2, m_rd, m_imm, m_f3, m_op, m_alu, m_ill}, {q[0].pc, q[0].m});
        chk("data_nc", {n_pc, n_rs1, n_rs2, n_rd, n_imm, n_f3, n_op, n_alu, n_ill}, {q[0].pc, q[0].n});
      end
    end
  endtask

  initial begin
    vt[0]  = '{32'h41040FB3, C_R,     A_SUB, 32'h00000000, 5'd8,  5'd16, 5'd31, 1'b0, 1'b0};
    vt[1]  = '{32'hFFD14093, C_I,     A_XOR, 32'hFFFFFFFD, 5'd2,  5'd0,  5'd1,  1'b0, 1'b0};
    vt[2]  = '{32'h00EC7163, C_BR,    A_GEU, 32'h00000002, 5'd24, 5'd14, 5'd0,  1'b0, 1'b0};
    vt[3]  = '{32'h00000000, -1,      -1,    32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1};
    vt[4]  = '{32'h02000033, -1,      -1,    32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0};
    vt[5]  = '{32'h0000B003, -1,      -1,    32'h00000000, 5'd1,  5'd0,  5'd0,  1'b1, 1'b0};
    vt[6]  = '{32'h123450B7, C_LUI,   A_ADD, 32'h12345000, 5'd0,  5'd0,  5'd1,  1'b0, 1'b0};
    vt[7]  = '{32'hFFDFF0EF, C_JAL,   A_ADD, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd1,  1'b0, 1'b0};
    vt[8]  = '{32'h00112623, C_STORE, A_ADD, 32'h0000000C, 5'd2,  5'd1,  5'd0,  1'b0, 1'b0};
    vt[9]  = '{32'h4020D093, C_I,     A_SRA, 32'h00000402, 5'd1,  5'd0,  5'd1,  1'b0, 1'b0};
    vt[10] = '{32'h00001067, -1,      -1,    32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0};

    rst_n = 1'b0; vld = 1'b0; flush = 1'b0; rdy = 1'b1; inst = '0; pc = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Directed decode table, back to back with execute always ready.
    for (int i = 0; i < 11; i++) begin
      inst = vt[i].inst; pc = 32'(i * 4); vld = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), m_valid, 1'b1);
      chk($sformatf("vec%0d_op_alu", i), {m_op, m_alu}, {oh11(vt[i].op), oh14(vt[i].alu)});
      chk($sformatf("vec%0d_imm", i), m_imm, vt[i].imm);
      chk($sformatf("vec%0d_regs", i), {m_rs1, m_rs2, m_rd}, {vt[i].rs1, vt[i].rs2, vt[i].rd});
      chk($sformatf("vec%0d_illegal", i), {m_ill, n_ill}, {vt[i].ill, vt[i].ill_nc});
    end
    vld = 1'b0;
    step();

    // Stall with three offers: third refused, then drained in order.
    rdy = 1'b0; vld = 1'b1;
    inst = 32'h00108093; pc = 32'h100; step();
    inst = 32'h00210113; pc = 32'h104; step();
    chk("stall_ready_drop", m_ready, 1'b0);
    inst = 32'h00318193; pc = 32'h108; step(); step();
    chk("stall_hold_pc", m_pc, 32'h100);
    rdy = 1'b1; step();
    chk("drain_second", m_pc, 32'h104);
    step();
    chk("drain_third", {m_valid, m_pc}, {1'b1, 32'h108});
    vld = 1'b0; step();
    chk("drain_empty", m_valid, 1'b0);

    // Flush with both entries full and a same-cycle offer.
    rdy = 1'b0; vld = 1'b1;
    inst = 32'h00400213; pc = 32'h200; step();
    inst = 32'h00500293; pc = 32'h204; step();
    inst = 32'h00600313; pc = 32'h208; flush = 1'b1; step();
    chk("flush_state", {m_valid, m_ready}, 2'b01);
    flush = 1'b0; vld = 1'b0; rdy = 1'b1; step(); step();
    chk("flush_nothing_left", m_valid, 1'b0);

    // Reset pulse in the middle of a stream.
    vld = 1'b1; inst = 32'h00700393; pc = 32'h300; step();
    inst = 32'h00800413; pc = 32'h304; step();
    rst_n = 1'b0; step();
    chk("midreset_ready_low", m_ready, 1'b0);
    rst_n = 1'b1; step();
    chk("midreset_ready_back", m_ready, 1'b1);
    vld = 1'b0; step();

    // Random traffic with random backpressure and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      inst  = rand_inst();
      pc    = $urandom();
      vld   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
